// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the datapath select muxes.
//   clog2()      : constant-evaluable ceiling log2, used to size select fields
//   dst_sel_e    : destination-register select encodings (rt / rd / $ra)
//   REG_ADDR_W   : register-file address width
// ----------------------------------------------------------------------------
package mux_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SEL_RT = 2'd0,
    SEL_RD = 2'd1,
    SEL_RA = 2'd2
  } dst_sel_e;

  // Ceiling log2, floored at 1 so a select field is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage : mux_pkg

// File: rtl/pipe_mux_n_if.sv
// ----------------------------------------------------------------------------
// pipe_mux_n_if
// Upstream/downstream handshake bundle for pipe_mux_n.
//   in_data   : N_IN flattened WIDTH-bit inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel    : binary select, qualified by in_valid
//   in_valid  : upstream item present
//   in_ready  : mux can accept this cycle
//   out_data  : registered selected value
//   out_err   : registered out-of-range flag for the item on out_data
//   out_valid : out_data / out_err valid
//   out_ready : downstream accepts this cycle
// Modports: slave = the mux, master = the environment driving it.
// ----------------------------------------------------------------------------
interface pipe_mux_n_if
  import mux_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int N_IN  = 3,
  localparam int SEL_W = clog2(N_IN)
);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

endinterface : pipe_mux_n_if

// File: rtl/mux_n_comb.sv
// ----------------------------------------------------------------------------
// mux_n_comb
// Purely combinational N-way, WIDTH-bit select with out-of-range detection.
//   in_data : N_IN flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel     : binary select
//   data    : selected input, or 0 when sel >= N_IN
//   err     : 1 when sel >= N_IN
// ----------------------------------------------------------------------------
module mux_n_comb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int N_IN  = 3,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  err
);

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    data = '0;
    err  = 1'b1;
    // Any select that matches no input falls through to data=0, err=1.
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule : mux_n_comb

// File: rtl/pipe_mux_n.sv
// ----------------------------------------------------------------------------
// pipe_mux_n
// N-way, WIDTH-bit mux with a registered, valid/ready output stage backed by a
// one-entry skid register (2-deep FIFO), flush and out-of-range detection.
//   clk      : rising-edge clock
//   rst      : synchronous, active-high reset
//   flush    : drop all held items and any item offered this cycle
//   bus      : pipe_mux_n_if.slave handshake bundle (in_* / out_*)
//   err_seen : sticky flag, set by any accepted out-of-range select
// in_ready depends only on registers and rst, so there is no combinational
// path from out_ready back to in_ready.
// ----------------------------------------------------------------------------
module pipe_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int N_IN  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_mux_n_if.slave       bus,
  output logic              err_seen
);

  // Main register M drives the outputs; skid register S catches one item
  // accepted while M is stalled.
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             m_err_q,   m_err_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic             s_err_q,   s_err_d;
  logic             err_seen_q, err_seen_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             pop;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_sel (
    .in_data (bus.in_data),
    .sel     (bus.in_sel),
    .data    (sel_data),
    .err     (sel_err)
  );

  assign bus.in_ready  = !rst && !s_valid_q;
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign pop           = m_valid_q && bus.out_ready;

  assign bus.out_valid = m_valid_q;
  assign bus.out_data  = m_data_q;
  assign bus.out_err   = m_err_q;
  assign err_seen      = err_seen_q;

  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_err_d    = m_err_q;
    s_valid_d  = s_valid_q;
    s_data_d   = s_data_q;
    s_err_d    = s_err_q;
    err_seen_d = err_seen_q || (accept && sel_err);

    if (flush) begin
      // Contents are left as-is; only the valid bits matter after a flush.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || pop) begin
      // M is free next cycle. S (older) has priority; S full implies
      // in_ready=0, so no accept can race with the S->M move.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_err_d   = s_err_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = sel_data;
        m_err_d   = sel_err;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      // M stalled: park the new item in S, which drops in_ready next cycle.
      s_valid_d = 1'b1;
      s_data_d  = sel_data;
      s_err_d   = sel_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  // NOTE: all storage, data included, is reset; it is a handful of flops and
  // keeps out_data at 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_err_q    <= 1'b0;
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      s_err_q    <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      s_err_q    <= s_err_d;
      err_seen_q <= err_seen_d;
    end
  end

endmodule : pipe_mux_n
